axi4_lite_master: RTL and testbench
===================================

# axi4_lite_master

AXI4-Lite initiator that converts a single-beat memory request from the cache/CPU side into AXI4-Lite write or read transactions. It drives the same AW/W/B/AR/R channels that the BRAM-backed AXI4-Lite slave consumes, and returns write completion or read data to the requester. One transaction is outstanding at a time. Write address and write data are issued concurrently, and each channel completes independently.

## Interface
- DATA_W, 32, data width (bits); must be a multiple of 8
- ADDR_W, 32, address width (bits)

- ACLK  in  1  clock; all logic is rising-edge
- ARESETn  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY
- REQ_WE  in  1  1=write, 0=read
- REQ_ADDR  in  ADDR_W  byte address
- REQ_WDATA  in  DATA_W  write data
- REQ_STRB  in  DATA_W/8  byte strobes (write only)
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  DATA_W  read data (valid with RSP_VALID on reads)
- RSP_ERR  out  1  error flag, qualified by RSP_VALID
- AW_VALID/AW_READY/AW_ADDR, W_VALID/W_READY/W_DATA/W_STRB, B_VALID/B_READY/B_RESP[1:0], AR_VALID/AR_READY/AR_ADDR, R_VALID/R_READY/R_DATA/R_RESP[1:0]: AXI4-Lite initiator-side channels. Widths are ADDR_W, DATA_W, DATA_W/8 and 2.

## Operation
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: REQ_READY=1. On acceptance, the block latches addr/wdata/strb/we.
  - REQ_WE=1 -> WR. REQ_WE=0 -> RD_ADDR.
- WR: AW_VALID and W_VALID are asserted together.
  - Each VALID drops in the cycle after its own handshake. Per-channel done flags track completion.
  - Once both flags are set -> WR_RESP. The AW and W handshakes may occur in either order or in the same cycle.
- WR_RESP: B_READY=1. On the B handshake, the block captures RSP_ERR = B_RESP[1] -> DONE.
- RD_ADDR: AR_VALID=1. On the AR handshake -> RD_DATA.
- RD_DATA: R_READY=1. On the R handshake, the block captures R_DATA into RSP_RDATA and sets RSP_ERR = R_RESP[1] -> DONE.
- DONE: RSP_VALID=1 for exactly one cycle -> IDLE. The requester must sample in that cycle; there is no backpressure on the response.
- VALID stability: once asserted, a VALID and its payload hold unchanged until the handshake. They are never withdrawn.
- All AXI outputs and RSP_* are registered. No combinational path exists from any *_READY input to a *_VALID output.
- AW_ADDR and AR_ADDR carry the latched REQ_ADDR unmodified. W_STRB carries REQ_STRB unmodified; a strobe of 0 is legal and is issued.
- RSP_RDATA holds its last captured value until the next read completes. Writes leave it unchanged.

## Timing
- Reset values:
  - all *_VALID=0, B_READY=0, R_READY=0, REQ_READY=0 while ARESETn=0
  - REQ_READY=1 on the first cycle after deassertion
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0
  - FSM=IDLE
- Reset mid-transaction: the FSM and all outputs clear asynchronously and no response is produced. The slave shares ARESETn, so the protocol state stays consistent.
- Minimum write (AW_READY, W_READY and B_VALID all ready):
  - accept at cycle 0
  - AW/W handshake at cycle 1
  - B handshake at cycle 2
  - RSP_VALID at cycle 3
  - REQ_READY again at cycle 4
- Minimum read:
  - accept at cycle 0
  - AR handshake at cycle 1
  - R handshake at cycle 2
  - RSP_VALID at cycle 3
- Any slave stall cycle adds one cycle to the total, one-for-one.
- A B_VALID or R_VALID that arrives early is held off by the slave and accepted once the block reaches the corresponding state.

## Configuration
- AXI_MASTER_ALIGN_CHK_EN defined:
  - A request with REQ_ADDR[$clog2(DATA_W/8)-1:0] != 0 issues no AXI transaction.
  - The FSM goes IDLE -> DONE, and RSP_VALID pulses with RSP_ERR=1 in the cycle after acceptance.
  - RSP_RDATA is unchanged.
- Undefined: the check logic is absent, and misaligned addresses pass to the bus unmodified.

## Test plan
- Write 0xDEADBEEF to 0x10 with strb 0xF, slave zero-wait -> AW_ADDR=0x10, W_DATA=0xDEADBEEF, RSP_VALID at cycle 3, RSP_ERR=0.
- Read 0x10 after that write, slave returning 0xDEADBEEF -> RSP_RDATA=0xDEADBEEF at cycle 3, RSP_ERR=0.
- Write to 0x20 with AW_READY held low 3 cycles while W_READY=1 -> W handshakes at cycle 1, AW_VALID stays high until the AW handshake at cycle 4, RSP_VALID at cycle 6.
- Read to 0x30 with slave R_RESP=2'b10 and R_DATA=0x12345678 -> RSP_ERR=1, RSP_RDATA=0x12345678.
- ARESETn pulsed low during WR_RESP -> all VALIDs 0 immediately, no RSP_VALID, REQ_READY=1 on the first cycle after release.
- With AXI_MASTER_ALIGN_CHK_EN: read of 0x13 -> AR_VALID never asserts, RSP_VALID with RSP_ERR=1 at cycle 1.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one single-beat request into an AW/W/B or AR/R transaction, one outstanding at a time.
// Optional AXI_MASTER_ALIGN_CHK_EN rejects misaligned requests with an error response and no bus traffic.
module axi4_lite_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                i_aclk,
  input  logic                i_aresetn,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_strb,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_aw_valid,
  input  logic                i_aw_ready,
  output logic [ADDR_W-1:0]   o_aw_addr,
  output logic                o_w_valid,
  input  logic                i_w_ready,
  output logic [DATA_W-1:0]   o_w_data,
  output logic [DATA_W/8-1:0] o_w_strb,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [1:0]          i_b_resp,
  output logic                o_ar_valid,
  input  logic                i_ar_ready,
  output logic [ADDR_W-1:0]   o_ar_addr,
  input  logic                i_r_valid,
  output logic                o_r_ready,
  input  logic [DATA_W-1:0]   i_r_data,
  input  logic [1:0]          i_r_resp
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_req_rdy, r_aw_vld, r_w_vld, r_b_rdy, r_ar_vld, r_r_rdy, r_rsp_vld, r_rsp_err;
  logic                r_aw_done, r_w_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [DATA_W/8-1:0] r_strb;

  logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_misalign;
  logic w_aw_done_nxt, w_w_done_nxt;
  logic w_req_rdy_nxt, w_aw_vld_nxt, w_w_vld_nxt, w_b_rdy_nxt, w_ar_vld_nxt, w_r_rdy_nxt, w_rsp_vld_nxt;
  logic w_unused;

  assign w_accept = i_req_valid & r_req_rdy;
  assign w_aw_hs  = r_aw_vld & i_aw_ready;
  assign w_w_hs   = r_w_vld & i_w_ready;
  assign w_b_hs   = r_b_rdy & i_b_valid;
  assign w_ar_hs  = r_ar_vld & i_ar_ready;
  assign w_r_hs   = r_r_rdy & i_r_valid;
  assign w_unused = i_b_resp[0] ^ i_r_resp[0];

`ifdef AXI_MASTER_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W/8 - 1);
  assign w_misalign = |(i_req_addr & ALIGN_MASK);
`else
  assign w_misalign = 1'b0;
`endif

  // AW and W complete independently; a done flag remembers a handshake that beat the other channel.
  assign w_aw_done_nxt = (r_state == S_WR) & (r_aw_done | w_aw_hs);
  assign w_w_done_nxt  = (r_state == S_WR) & (r_w_done | w_w_hs);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_misalign)    w_state_nxt = S_DONE;
        else if (i_req_we) w_state_nxt = S_WR;
        else               w_state_nxt = S_RD_ADDR;
      end
      S_WR:      if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (w_b_hs)  w_state_nxt = S_DONE;
      S_RD_ADDR: if (w_ar_hs) w_state_nxt = S_RD_DATA;
      S_RD_DATA: if (w_r_hs)  w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they belong to.
  always_comb begin
    w_req_rdy_nxt = (w_state_nxt == S_IDLE);
    w_aw_vld_nxt  = (w_state_nxt == S_WR) & ~w_aw_done_nxt;
    w_w_vld_nxt   = (w_state_nxt == S_WR) & ~w_w_done_nxt;
    w_b_rdy_nxt   = (w_state_nxt == S_WR_RESP);
    w_ar_vld_nxt  = (w_state_nxt == S_RD_ADDR);
    w_r_rdy_nxt   = (w_state_nxt == S_RD_DATA);
    w_rsp_vld_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_req_rdy <= 1'b0;
      r_aw_vld  <= 1'b0;
      r_w_vld   <= 1'b0;
      r_b_rdy   <= 1'b0;
      r_ar_vld  <= 1'b0;
      r_r_rdy   <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_err <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
    end else begin
      r_req_rdy <= w_req_rdy_nxt;
      r_aw_vld  <= w_aw_vld_nxt;
      r_w_vld   <= w_w_vld_nxt;
      r_b_rdy   <= w_b_rdy_nxt;
      r_ar_vld  <= w_ar_vld_nxt;
      r_r_rdy   <= w_r_rdy_nxt;
      r_rsp_vld <= w_rsp_vld_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_strb  <= i_req_strb;
      end
      if (w_accept && w_misalign) r_rsp_err <= 1'b1;
      if (w_b_hs) r_rsp_err <= i_b_resp[1];
      if (w_r_hs) begin
        r_rsp_err <= i_r_resp[1];
        r_rdata   <= i_r_data;
      end
    end
  end

  assign o_req_ready = r_req_rdy;
  assign o_rsp_valid = r_rsp_vld;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_aw_valid  = r_aw_vld;
  assign o_aw_addr   = r_addr;
  assign o_w_valid   = r_w_vld;
  assign o_w_data    = r_wdata;
  assign o_w_strb    = r_strb;
  assign o_b_ready   = r_b_rdy;
  assign o_ar_valid  = r_ar_vld;
  assign o_ar_addr   = r_addr;
  assign o_r_ready   = r_r_rdy;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: the bench plays requester and slave, checking outputs on the falling edge.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_master #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_aclk(clk), .i_aresetn(aresetn),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_strb(req_strb),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_aw_valid(aw_valid), .i_aw_ready(aw_ready), .o_aw_addr(aw_addr),
    .o_w_valid(w_valid), .i_w_ready(w_ready), .o_w_data(w_data), .o_w_strb(w_strb),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_resp(b_resp),
    .o_ar_valid(ar_valid), .i_ar_ready(ar_ready), .o_ar_addr(ar_addr),
    .i_r_valid(r_valid), .o_r_ready(r_ready), .i_r_data(r_data), .i_r_resp(r_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Presents a request in the current cycle (cycle 0); it is accepted on the next rising edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_strb  = strb;
    chk("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;

    repeat (2) cyc();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_aw_valid",  {31'd0, aw_valid},  32'd0);
    chk("rst_ar_valid",  {31'd0, ar_valid},  32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    aresetn = 1'b1;
    cyc();
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Zero-wait write of 0xDEADBEEF to 0x10
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    cyc(); req_valid = 1'b0;
    chk("wr1_aw_valid", {31'd0, aw_valid}, 32'd1);
    chk("wr1_w_valid",  {31'd0, w_valid},  32'd1);
    chk("wr1_aw_addr",  aw_addr, 32'h10);
    chk("wr1_w_data",   w_data,  32'hDEADBEEF);
    chk("wr1_w_strb",   {28'd0, w_strb}, 32'hF);
    chk("wr1_req_ready_busy", {31'd0, req_ready}, 32'd0);
    cyc();
    chk("wr1_aw_dropped", {31'd0, aw_valid}, 32'd0);
    chk("wr1_w_dropped",  {31'd0, w_valid},  32'd0);
    chk("wr1_b_ready",    {31'd0, b_ready},  32'd1);
    chk("wr1_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    cyc();
    chk("wr1_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    chk("wr1_rsp_err",      {31'd0, rsp_err},   32'd0);
    chk("wr1_b_ready_low",  {31'd0, b_ready},   32'd0);
    cyc();
    chk("wr1_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("wr1_req_ready_c4",  {31'd0, req_ready}, 32'd1);
    b_valid = 1'b0;

    // Zero-wait read of 0x10 returning 0xDEADBEEF
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'hDEADBEEF; r_resp = 2'b00;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    cyc(); req_valid = 1'b0;
    chk("rd1_ar_valid", {31'd0, ar_valid}, 32'd1);
    chk("rd1_ar_addr",  ar_addr, 32'h10);
    chk("rd1_no_aw",    {31'd0, aw_valid}, 32'd0);
    cyc();
    chk("rd1_ar_dropped", {31'd0, ar_valid}, 32'd0);
    chk("rd1_r_ready",    {31'd0, r_ready},  32'd1);
    cyc();
    chk("rd1_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    chk("rd1_rdata",        rsp_rdata, 32'hDEADBEEF);
    chk("rd1_rsp_err",      {31'd0, rsp_err}, 32'd0);
    cyc(); r_valid = 1'b0;
    chk("rd1_req_ready", {31'd0, req_ready}, 32'd1);

    // Write to 0x20 with AW stalled 3 cycles, zero strobe, SLVERR on B
    aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b10;
    issue(1'b1, 32'h20, 32'hCAFEF00D, 4'h0);
    cyc(); req_valid = 1'b0;
    chk("wr2_c1_aw_valid", {31'd0, aw_valid}, 32'd1);
    chk("wr2_c1_w_valid",  {31'd0, w_valid},  32'd1);
    chk("wr2_zero_strb",   {28'd0, w_strb},   32'h0);
    cyc();
    chk("wr2_c2_aw_held", {31'd0, aw_valid}, 32'd1);
    chk("wr2_c2_w_done",  {31'd0, w_valid},  32'd0);
    chk("wr2_c2_aw_addr", aw_addr, 32'h20);
    cyc();
    chk("wr2_c3_aw_held",  {31'd0, aw_valid}, 32'd1);
    chk("wr2_c3_no_bready", {31'd0, b_ready}, 32'd0);
    cyc(); aw_ready = 1'b1;
    chk("wr2_c4_aw_held", {31'd0, aw_valid}, 32'd1);
    cyc();
    chk("wr2_c5_aw_dropped", {31'd0, aw_valid}, 32'd0);
    chk("wr2_c5_b_ready",    {31'd0, b_ready},  32'd1);
    chk("wr2_c5_no_rsp",     {31'd0, rsp_valid}, 32'd0);
    cyc();
    chk("wr2_rsp_valid_c6", {31'd0, rsp_valid}, 32'd1);
    chk("wr2_rsp_err_b",    {31'd0, rsp_err},   32'd1);
    chk("wr2_rdata_kept",   rsp_rdata, 32'hDEADBEEF);
    cyc(); b_valid = 1'b0; b_resp = 2'b00;

    // Read of 0x30 with SLVERR and data 0x12345678
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h12345678; r_resp = 2'b10;
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    cyc(); req_valid = 1'b0;
    chk("rd2_ar_addr", ar_addr, 32'h30);
    cyc();
    cyc();
    chk("rd2_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    chk("rd2_rsp_err",      {31'd0, rsp_err},   32'd1);
    chk("rd2_rdata",        rsp_rdata, 32'h12345678);
    cyc(); r_valid = 1'b0; r_resp = 2'b00;

    // Reset pulse while waiting in WR_RESP
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
    issue(1'b1, 32'h40, 32'h55AA55AA, 4'hF);
    cyc(); req_valid = 1'b0;
    cyc();
    chk("rstmid_b_ready_before", {31'd0, b_ready}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("rstmid_b_ready",   {31'd0, b_ready},   32'd0);
    chk("rstmid_aw_valid",  {31'd0, aw_valid},  32'd0);
    chk("rstmid_w_valid",   {31'd0, w_valid},   32'd0);
    chk("rstmid_ar_valid",  {31'd0, ar_valid},  32'd0);
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cyc(); aresetn = 1'b1;
    cyc();
    chk("rstmid_req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rstmid_no_rsp_1",        {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_rdata_cleared",   rsp_rdata, 32'd0);
    cyc();
    chk("rstmid_no_rsp_2", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_idle_aw",  {31'd0, aw_valid},  32'd0);

`ifdef AXI_MASTER_ALIGN_CHK_EN
    // Misaligned read is refused without touching the bus
    ar_ready = 1'b1;
    issue(1'b0, 32'h13, 32'h0, 4'h0);
    cyc(); req_valid = 1'b0;
    chk("align_rsp_valid_c1", {31'd0, rsp_valid}, 32'd1);
    chk("align_rsp_err",      {31'd0, rsp_err},   32'd1);
    chk("align_no_ar",        {31'd0, ar_valid},  32'd0);
    chk("align_rdata_kept",   rsp_rdata, 32'd0);
    cyc();
    chk("align_no_ar_2",     {31'd0, ar_valid},  32'd0);
    chk("align_req_ready",   {31'd0, req_ready}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
